// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counters library.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Wide enough to hold any modulus up to 2**32 without truncation.
  localparam int unsigned CMP_W = 33;

  function automatic logic [CMP_W-1:0] clamp_mod(input logic [CMP_W-1:0] value,
                                                 input logic [CMP_W-1:0] modulus);
    return (value >= modulus) ? (modulus - CMP_W'(1)) : value;
  endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with load, clear, enable, wrap/saturate mode,
// terminal-count flag and registered wrap/saturation event pulse.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);

  localparam int unsigned     XW      = WIDTH + 1;
  localparam logic [XW-1:0]   MOD_X   = XW'(MODULUS);
  localparam logic [XW-1:0]   MAX_X   = MOD_X - XW'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_X);
  localparam logic            SAT     = (SATURATE == MODE_SAT);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be 2..2**WIDTH");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("counter_updown_mod: SATURATE must be 0 or 1");
  end

  logic [XW-1:0]    count_x;
  logic             at_top;
  logic             at_zero;
  logic             dir_up;
  logic             at_bound;
  logic             refused;
  logic             blocked;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_cnt;

  // Bound detection and next step value, all modulo MODULUS.
  always_comb begin
    count_x  = {1'b0, count};
    at_top   = (count_x == MAX_X);
    at_zero  = (count == '0);
    dir_up   = (up_dn == CNT_UP);
    at_bound = dir_up ? at_top : at_zero;
    refused  = en && at_bound && SAT;
    if (dir_up) begin
      step_val = at_top ? '0 : (count + WIDTH'(1));
    end else begin
      step_val = at_zero ? CNT_MAX : (count - WIDTH'(1));
    end
    load_cnt = WIDTH'(clamp_mod(CMP_W'(load_val), CMP_W'(MODULUS)));
  end

  assign tc = ((up_dn == CNT_UP) && at_top) || ((up_dn == CNT_DN) && at_zero);

  // Count state; 'blocked' remembers a refused step so evt fires only once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      evt     <= 1'b0;
      blocked <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      evt     <= 1'b0;
      blocked <= 1'b0;
    end else if (load) begin
      count   <= load_cnt;
      evt     <= 1'b0;
      blocked <= 1'b0;
    end else if (en) begin
      if (refused) begin
        evt     <= !blocked;
        blocked <= 1'b1;
      end else begin
        count   <= step_val;
        evt     <= at_bound;
        blocked <= 1'b0;
      end
    end else begin
      evt     <= 1'b0;
      blocked <= 1'b0;
    end
  end

endmodule
